// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage request/response channel into dmem_responder
//   req_valid/req_ready : request handshake, accepted when both are high at a clk edge
//   req_we, req_half    : store/load select, halfword/word select
//   req_addr, req_wdata : byte address and store data
//   resp_valid          : one-cycle response pulse qualifying resp_rdata and resp_err
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_half;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   modport master (
      output req_valid, req_we, req_half, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );
   modport slave (
      input  req_valid, req_we, req_half, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data memory with word and sign-extended halfword access
//   clk            : system clock, rising edge
//   reset          : synchronous, active-low
//   bus            : slave side of dmem_responder_if (request channel and response pulse)
//   busy           : a request is in flight
//   rd_cnt, wr_cnt : non-error load/store counters, present only with DMEM_STATS_EN defined
module dmem_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus,
   output logic            busy
`ifdef DMEM_STATS_EN
   ,
   output logic [31:0]     rd_cnt,
   output logic [31:0]     wr_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t              state;
   logic [3:0]          cnt;
   logic                we_q, half_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic [31:0]         mem [2**ADDR_W] = '{default: '0};
   logic                idle, a_we, a_half, mis, commit, unused_addr;
   logic [ADDR_W+1:0]   a_addr;
   logic [ADDR_W-1:0]   idx;
   logic [31:0]         a_wdata, word, ld_data, st_word;
   logic [15:0]         hw;
   // With zero wait cycles the access commits on the accept edge itself, so the
   // operands come straight from the bus while idle and from the latches otherwise.
   assign idle        = state == IDLE;
   assign a_we        = idle ? bus.req_we : we_q;
   assign a_half      = idle ? bus.req_half : half_q;
   assign a_addr      = idle ? bus.req_addr[ADDR_W+1:0] : addr_q;
   assign a_wdata     = idle ? bus.req_wdata : wdata_q;
   assign idx         = a_addr[ADDR_W+1:2];
   assign mis         = a_half ? a_addr[0] : |a_addr[1:0];
   assign commit      = idle ? bus.req_valid && WAIT_CYCLES == 0 : state == WAIT && cnt == 4'd0;
   assign word        = mem[idx];
   assign hw          = a_addr[1] ? word[31:16] : word[15:0];
   assign ld_data     = a_half ? {{16{hw[15]}}, hw} : word;
   assign st_word     = !a_half ? a_wdata :
                        a_addr[1] ? {a_wdata[15:0], word[15:0]} : {word[31:16], a_wdata[15:0]};
   assign bus.req_ready = idle;
   assign busy          = !idle;
   // Upper address bits alias onto the same words by design.
   assign unused_addr   = ^bus.req_addr[31:ADDR_W+2];
   // Reset wins over a commit on the same edge, so an abandoned store never lands.
   always_ff @(posedge clk)
      if (reset && commit && a_we && !mis) mem[idx] <= st_word;
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         cnt            <= '0;
         we_q           <= 1'b0;
         half_q         <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
`ifdef DMEM_STATS_EN
         rd_cnt         <= '0;
         wr_cnt         <= '0;
`endif
      end else begin
         // commit is exactly the edge entering RESP, so this yields a one-cycle pulse.
         bus.resp_valid <= commit;
         bus.resp_err   <= commit && mis;
         bus.resp_rdata <= commit && !a_we && !mis ? ld_data : '0;
`ifdef DMEM_STATS_EN
         if (commit && !mis && a_we) wr_cnt <= wr_cnt + 32'd1;
         if (commit && !mis && !a_we) rd_cnt <= rd_cnt + 32'd1;
`endif
         case (state)
            IDLE: if (bus.req_valid) begin
               we_q    <= bus.req_we;
               half_q  <= bus.req_half;
               addr_q  <= bus.req_addr[ADDR_W+1:0];
               wdata_q <= bus.req_wdata;
               cnt     <= 4'(WAIT_CYCLES - 1);
               state   <= WAIT_CYCLES == 0 ? RESP : WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0) state <= RESP;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, directed corner sequences and random traffic against a reference model
module tb_dmem_responder;
   localparam int ADDR_W      = 10;
   localparam int WAIT_CYCLES = 1;
   localparam int DEPTH       = 1 << ADDR_W;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic busy;
`ifdef DMEM_STATS_EN
   logic [31:0] rd_cnt, wr_cnt;
`endif
   int total = 0;
   int bad = 0;

   dmem_responder_if bus();

   dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .busy(busy)
`ifdef DMEM_STATS_EN
      ,
      .rd_cnt(rd_cnt),
      .wr_cnt(wr_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: sparse word store keyed by word index, plus commit counters.
   logic [31:0] ref_mem [int];
   int ref_rd = 0;
   int ref_wr = 0;

   function automatic void model(input logic we, input logic half, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
      int i = int'((addr >> 2) % DEPTH);
      logic [31:0] w = ref_mem.exists(i) ? ref_mem[i] : 32'h0;
      int sh = (addr % 4 >= 2) ? 16 : 0;
      logic [31:0] h = (w >> sh) & 32'hFFFF;
      err = half ? (addr % 2 != 0) : (addr % 4 != 0);
      rdata = 32'h0;
      if (err) return;
      if (we) begin
         ref_mem[i] = half ? ((w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh)) : wdata;
         ref_wr++;
      end else begin
         rdata = half ? (h >= 32'h8000 ? h - 32'h10000 : h) : w;
         ref_rd++;
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic xact(input logic we, input logic half, input logic [31:0] addr, input logic [31:0] wdata,
                       input int gap, output logic [31:0] rdata, output logic err, output int lat);
      int n = 0;
      rdata = 'x;
      err = 1'bx;
      lat = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_half  = half;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'($urandom);
      bus.req_half  = 1'($urandom);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            lat = c;
            rdata = bus.resp_rdata;
            err = bus.resp_err;
            break;
         end
      end
      repeat (gap) @(negedge clk);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      ref_rd = 0;
      ref_wr = 0;
   endtask

   typedef struct {
      logic        we;
      logic        half;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   vec_t vecs[14];

   initial begin
      logic [31:0] rd, mr;
      logic er, me;
      int lat, pulses;
      logic rdy_h[16];
      int acc[$];

      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, mr;
      logic er, me;
      int lat, pulses;
      logic rdy_h[16];
      int acc[$];

      vecs[0]  = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h20, 32'h12345678, 32'h0,        1'b0};
      vecs[3]  = '{1'b1, 1'b1, 32'h22, 32'h0000ABCD, 32'h0,        1'b0};
      vecs[4]  = '{1'b0, 1'b0, 32'h20, 32'h0,        32'hABCD5678, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 32'h22, 32'h0,        32'hFFFFABCD, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'h20, 32'h0,        32'h00005678, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 32'h31, 32'h11111111, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 1'b0, 32'h30, 32'h0,        32'h0,        1'b0};
      vecs[9]  = '{1'b1, 1'b1, 32'h25, 32'h00007777, 32'h0,        1'b1};
      vecs[10] = '{1'b0, 1'b0, 32'h24, 32'h0,        32'h0,        1'b0};
      vecs[11] = '{1'b0, 1'b1, 32'h23, 32'h0,        32'h0,        1'b1};
      vecs[12] = '{1'b1, 1'b1, 32'h20, 32'hFFFF8001, 32'h0,        1'b0};
      vecs[13] = '{1'b0, 1'b1, 32'h20, 32'h0,        32'hFFFF8001, 1'b0};

      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_half  = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;

      // Reset held for three edges, then released.
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rdata", bus.resp_rdata, 32'h0);
      chk("rst_err", 32'(bus.resp_err), 32'd0);

      // Directed vectors.
      foreach (vecs[k]) begin
         xact(vecs[k].we, vecs[k].half, vecs[k].addr, vecs[k].wdata, 0, rd, er, lat);
         model(vecs[k].we, vecs[k].half, vecs[k].addr, vecs[k].wdata, mr, me);
         chk($sformatf("vec%0d_rdata", k), rd, vecs[k].rdata);
         chk($sformatf("vec%0d_err", k), 32'(er), 32'(vecs[k].err));
         chk($sformatf("vec%0d_lat", k), 32'(lat), 32'(WAIT_CYCLES + 1));
      end

      // Back-to-back: req_valid held high across three loads.
      pulses = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_half  = 1'b0;
      bus.req_addr  = 32'h10;
      for (int c = 0; c < 16; c++) begin
         rdy_h[c] = bus.req_ready;
         if (bus.resp_valid) begin
            pulses++;
            chk("b2b_rdata", bus.resp_rdata, 32'hDEADBEEF);
         end
         if (bus.req_valid && bus.req_ready) begin
            acc.push_back(c);
            model(1'b0, 1'b0, 32'h10, 32'h0, mr, me);
            if (acc.size() == 3) begin
               @(posedge clk);
               #1 bus.req_valid = 1'b0;
            end
         end
         @(negedge clk);
      end
      chk("b2b_accepts", 32'(acc.size()), 32'd3);
      chk("b2b_pulses", 32'(pulses), 32'd3);
      if (acc.size() == 3) begin
         chk("b2b_spacing1", 32'(acc[1] - acc[0]), 32'(WAIT_CYCLES + 2));
         chk("b2b_spacing2", 32'(acc[2] - acc[1]), 32'(WAIT_CYCLES + 2));
         foreach (acc[k]) begin
            chk($sformatf("b2b_ready_low%0d_a", k), 32'(rdy_h[acc[k] + 1]), 32'd0);
            chk($sformatf("b2b_ready_low%0d_b", k), 32'(rdy_h[acc[k] + 2]), 32'd0);
         end
      end

      // Reset during WAIT of a store: no response, no write.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_half  = 1'b0;
      bus.req_addr  = 32'h40;
      bus.req_wdata = 32'h5;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      ref_rd = 0;
      ref_wr = 0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.resp_valid) pulses++;
         @(negedge clk);
      end
      chk("midrst_no_resp", 32'(pulses), 32'd0);
      chk("midrst_ready", 32'(bus.req_ready), 32'd1);
      xact(1'b0, 1'b0, 32'h40, 32'h0, 0, rd, er, lat);
      model(1'b0, 1'b0, 32'h40, 32'h0, mr, me);
      chk("midrst_load", rd, 32'h0);
      chk("midrst_lat", 32'(lat), 32'(WAIT_CYCLES + 1));

      // Aliasing: 0x1000 wraps onto word 0.
      pulse_reset();
      xact(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, 0, rd, er, lat);
      model(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, mr, me);
      chk("alias_store_err", 32'(er), 32'd0);
      xact(1'b0, 1'b0, 32'h0, 32'h0, 0, rd, er, lat);
      model(1'b0, 1'b0, 32'h0, 32'h0, mr, me);
      chk("alias_load", rd, 32'hCAFEF00D);
`ifdef DMEM_STATS_EN
      @(negedge clk);
      chk("alias_wr_cnt", wr_cnt, 32'd1);
      chk("alias_rd_cnt", rd_cnt, 32'd1);
`endif

      // Random traffic against the model.
      for (int k = 0; k < 300; k++) begin
         logic we, half;
         logic [31:0] addr, wdata;
         we    = 1'($urandom_range(0, 1));
         half  = 1'($urandom_range(0, 1));
         addr  = (32'($urandom_range(0, 3)) << (ADDR_W + 2)) | (32'($urandom_range(0, 15)) << 2);
         if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
         else if (half && $urandom_range(0, 1) == 1) addr = addr | 32'h2;
         wdata = $urandom;
         xact(we, half, addr, wdata, $urandom_range(0, 2), rd, er, lat);
         model(we, half, addr, wdata, mr, me);
         chk($sformatf("rnd%0d_rdata", k), rd, mr);
         chk($sformatf("rnd%0d_err", k), 32'(er), 32'(me));
         chk($sformatf("rnd%0d_lat", k), 32'(lat), 32'(WAIT_CYCLES + 1));
      end
`ifdef DMEM_STATS_EN
      @(negedge clk);
      chk("rnd_wr_cnt", wr_cnt, 32'(ref_wr));
      chk("rnd_rd_cnt", rd_cnt, 32'(ref_rd));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the pipeline's MEM-stage load/store requests over a valid/ready request channel and a one-cycle response pulse.
- Replaces the combinational data RAM with a handshaked, multi-cycle target so the CPU can stall on memory.
- Supports word and sign-extended halfword accesses.
- Flags misaligned accesses instead of corrupting memory.

Parameters:
- ADDR_W, 10, word-address bits; memory depth is 2**ADDR_W words.
- WAIT_CYCLES, 1, extra wait cycles between request accept and response; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-low: reset==0 at a rising clk edge resets the block.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_half  in  1  1 = halfword access, 0 = word access.
- req_addr  in  32  byte address; bits [ADDR_W+1:2] index the word, bit [1] selects the half.
- req_wdata  in  32  store data; a halfword store uses bits [15:0].
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data; valid only while resp_valid is high.
- resp_err  out  1  misaligned-access flag; valid only while resp_valid is high.
- busy  out  1  a request is in flight (state is not IDLE).

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset puts the FSM in IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, wait counter=0. Memory contents are not cleared by reset; they are zero-initialised at power-up.
- Accept rule: req_ready=1 only in IDLE. A request is accepted on a clk edge where req_valid & req_ready.
- On accept: latch we, half, addr and wdata. Next state is WAIT with counter=WAIT_CYCLES-1, or RESP directly if WAIT_CYCLES==0.
- WAIT: decrement the counter each cycle; when it reaches 0, go to RESP.
- Memory access happens on the clk edge that enters RESP:
  - Store: write memory.
  - Load: register resp_rdata.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Timing: latency from the accept edge to resp_valid high is WAIT_CYCLES+1 cycles. Peak throughput is one request per WAIT_CYCLES+2 cycles.
- Request inputs are ignored outside IDLE; the initiator must hold them only until accepted.
- Word load: resp_rdata = mem[idx].
- Halfword load: select mem[idx][31:16] if addr[1]=1, else [15:0]; sign-extend to 32 bits.
- Word store: mem[idx] = wdata.
- Halfword store: write wdata[15:0] into the selected half only; the other half is unchanged.
- Store response: resp_rdata=0.
- Misaligned access (word with addr[1:0]!=0, or half with addr[0]=1):
  - No memory write; resp_rdata=0; resp_err=1 with resp_valid. Same latency as a normal access.
- Address bits above ADDR_W+1 are ignored, so addresses alias (wrap) modulo memory size.
- Read-after-write: a load accepted after a store's resp_valid returns the stored data.
- Reset mid-operation: the in-flight request is abandoned with no response. A store not yet committed (still in WAIT) does not write; a store already committed stays written.
- resp_valid, resp_rdata and resp_err are registered outputs with no combinational input-to-output path. req_ready and busy are decoded from the state register only.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds outputs rd_cnt (32 bits) and wr_cnt (32 bits).
  - Each increments on the clk edge entering RESP for a non-error load or store respectively.
  - Counters wrap at 2**32 and clear to 0 on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset (WAIT_CYCLES=1): hold reset=0 for 3 cycles, then release. Expect req_ready=1, resp_valid=0, busy=0, resp_rdata=0 immediately after release.
- Word store then load: store addr=0x10, wdata=0xDEADBEEF, then load addr=0x10. Expect resp_valid exactly 2 cycles after each accept, and load resp_rdata=0xDEADBEEF with resp_err=0.
- Halfword store/load:
  - Word store 0x12345678 at 0x20, then half store wdata=0x0000ABCD at 0x22. Word load at 0x20 returns 0xABCD5678.
  - Half load at 0x22 returns 0xFFFFABCD; half load at 0x20 returns 0x00005678.
- Misaligned: word store to 0x31 with wdata=0x11111111 gives resp_err=1. A following word load at 0x30 returns the prior contents (0 after power-up), and resp_err=0.
- Back-to-back and mid-operation reset:
  - Hold req_valid high for 3 loads. Expect req_ready low for 2 cycles after each accept, accepts spaced 3 cycles apart, and exactly one resp_valid pulse per request.
  - Assert reset during WAIT of a store to 0x40 with wdata=0x5. Expect no response, and a later load of 0x40 returns 0.
- Aliasing (ADDR_W=10): store 0xCAFEF00D at 0x1000, then load 0x0000. Expect 0xCAFEF00D. With DMEM_STATS_EN defined, expect wr_cnt=1 and rd_cnt=1 at the end.
